// File: rtl/conv_bias_relu.sv
// conv_bias_relu: adds a per-output-channel FP32 bias to the adder-tree stream,
// rectifies the result and tracks plane/frame position on both sides.
// Optional build macro RELU6_EN: also clamps positive results above 6.0 to 6.0.

// Single-cycle IEEE-754 single-precision adder with round-to-nearest-even.
module fp_add_sub (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_valid
);

  logic        w_aNan, w_bNan, w_aInf, w_bInf, w_swap, w_sign;
  logic [31:0] w_big, w_small, w_res;
  logic [7:0]  w_eBig, w_eSmall, w_diff;
  logic [23:0] w_mBig, w_mSmall;
  logic [53:0] w_align;
  logic [26:0] w_smallAl, w_norm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp, w_shift;
  logic [24:0] w_round;
  logic [22:0] w_frac;

  // Align, add, normalise and round the two operands; special values bypass the datapath
  always_comb begin
    w_aNan    = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_bNan    = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
    w_aInf    = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_bInf    = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_swap    = i_b[30:0] > i_a[30:0];
    w_big     = w_swap ? i_b : i_a;
    w_small   = w_swap ? i_a : i_b;
    w_eBig    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_eSmall  = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
    w_mBig    = {(w_big[30:23] != 8'd0), w_big[22:0]};
    w_mSmall  = {(w_small[30:23] != 8'd0), w_small[22:0]};
    w_diff    = w_eBig - w_eSmall;
    w_align   = {w_mSmall, 3'b000, 27'd0} >> ((w_diff > 8'd27) ? 8'd27 : w_diff);
    w_smallAl = {w_align[53:28], w_align[27] | (|w_align[26:0])};
    if (w_big[31] != w_small[31])
      w_sum = {1'b0, w_mBig, 3'b000} - {1'b0, w_smallAl};
    else
      w_sum = {1'b0, w_mBig, 3'b000} + {1'b0, w_smallAl};
    w_sign = (w_sum == 28'd0) ? (i_a[31] & i_b[31]) : w_big[31];
    w_lz = 5'd27;
    for (int i = 0; i <= 26; i++)
      if (w_sum[i]) w_lz = 5'(26 - i);
    w_exp   = {2'b00, w_eBig};
    w_shift = 10'd0;
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp + 10'd1;
    end else begin
      w_shift = ({5'd0, w_lz} < (w_exp - 10'd1)) ? {5'd0, w_lz} : (w_exp - 10'd1);
      w_norm  = w_sum[26:0] << w_shift;
      w_exp   = w_exp - w_shift;
      if (!w_norm[26]) w_exp = 10'd0;
    end
    w_round = {1'b0, w_norm[26:3]} + {24'd0, w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3])};
    w_frac  = w_round[24] ? w_round[23:1] : w_round[22:0];
    if (w_round[24]) w_exp = w_exp + 10'd1;
    else if ((w_exp == 10'd0) && w_round[23]) w_exp = 10'd1;
    if (w_exp >= 10'd255) w_res = {w_sign, 8'hFF, 23'd0};
    else                  w_res = {w_sign, w_exp[7:0], w_frac};
    if (w_aNan)                                    w_res = i_a | 32'h0040_0000;
    else if (w_bNan)                               w_res = i_b | 32'h0040_0000;
    else if (w_aInf && w_bInf && (i_a[31] != i_b[31])) w_res = 32'h7FC0_0000;
    else if (w_aInf)                               w_res = i_a;
    else if (w_bInf)                               w_res = i_b;
  end

  // Pipeline register holding the sum and its valid flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_result <= w_res;
    end
  end

endmodule

module conv_bias_relu #(
  parameter  int DATA_WIDTH      = 32,
  parameter  int CHANNEL_NUM_OUT = 64,
  parameter  int IMAGE_SIZE      = 612,
  localparam int CH_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1,
  localparam int PX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  bias_wr_en,
  input  logic [CH_W-1:0]       bias_wr_addr,
  input  logic [DATA_WIDTH-1:0] bias_wr_data,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  last_px_out,
  output logic                  frame_done
);

  logic [DATA_WIDTH-1:0] r_bias [CHANNEL_NUM_OUT];
  logic [PX_W-1:0]       r_inPx, r_outPx;
  logic [CH_W-1:0]       r_inCh, r_outCh;
  logic [DATA_WIDTH-1:0] r_pxlOut;
  logic                  r_validOut, r_lastPx, r_frameDone;
  logic [DATA_WIDTH-1:0] w_bias, w_addResult, w_relu;
  logic                  w_addValid, w_addRst;
  logic                  w_inPxLast, w_inChLast, w_outPxLast, w_outChLast;

  assign w_bias      = r_bias[r_inCh];
  assign w_addRst    = ~reset;
  assign w_inPxLast  = (r_inPx == PX_W'(IMAGE_SIZE - 1));
  assign w_inChLast  = (r_inCh == CH_W'(CHANNEL_NUM_OUT - 1));
  assign w_outPxLast = (r_outPx == PX_W'(IMAGE_SIZE - 1));
  assign w_outChLast = (r_outCh == CH_W'(CHANNEL_NUM_OUT - 1));
  assign pxl_out     = r_pxlOut;
  assign valid_out   = r_validOut;
  assign last_px_out = r_lastPx;
  assign frame_done  = r_frameDone;

  fp_add_sub u_add (
    .i_clk    (clk),
    .i_rst    (w_addRst),
    .i_valid  (valid_in),
    .i_a      (pxl_in),
    .i_b      (w_bias),
    .o_result (w_addResult),
    .o_valid  (w_addValid)
  );

  // Bias register file; the read above sees the old value in the cycle of a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNEL_NUM_OUT; i++) r_bias[i] <= '0;
    end else if (bias_wr_en) begin
      for (int i = 0; i < CHANNEL_NUM_OUT; i++)
        if (bias_wr_addr == CH_W'(i)) r_bias[i] <= bias_wr_data;
    end
  end

  // Input-side position; selects which channel's bias the incoming pixel gets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inPx <= '0;
      r_inCh <= '0;
    end else if (valid_in) begin
      if (w_inPxLast) begin
        r_inPx <= '0;
        r_inCh <= w_inChLast ? '0 : r_inCh + 1'b1;
      end else begin
        r_inPx <= r_inPx + 1'b1;
      end
    end
  end

  // Rectifier: any negative result (including -0 and negative NaN) becomes +0
  always_comb begin
    w_relu = w_addResult[31] ? '0 : w_addResult;
`ifdef RELU6_EN
    if (!w_addResult[31] && (w_addResult > 32'h40C0_0000)) w_relu = 32'h40C0_0000;
`endif
  end

  // Output-side position advances with each pixel loaded into the output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outPx <= '0;
      r_outCh <= '0;
    end else if (w_addValid) begin
      if (w_outPxLast) begin
        r_outPx <= '0;
        r_outCh <= w_outChLast ? '0 : r_outCh + 1'b1;
      end else begin
        r_outPx <= r_outPx + 1'b1;
      end
    end
  end

  // Output register; position flags are captured alongside the pixel they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pxlOut    <= '0;
      r_validOut  <= 1'b0;
      r_lastPx    <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_validOut <= w_addValid;
      if (w_addValid) begin
        r_pxlOut    <= w_relu;
        r_lastPx    <= w_outPxLast;
        r_frameDone <= w_outPxLast & w_outChLast;
      end else begin
        r_lastPx    <= 1'b0;
        r_frameDone <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_bias_relu.sv
// Scoreboard bench for conv_bias_relu with 4 channels of 3-pixel planes.
// Honours RELU6_EN when the design is built with it.
module tb_conv_bias_relu;

  localparam int CNO = 4;
  localparam int IS  = 3;
  localparam int LAT = 2;

`ifdef RELU6_EN
  localparam logic [31:0] EXP_TEN = 32'h40C0_0000;
  localparam logic [31:0] EXP_NAN = 32'h40C0_0000;
`else
  localparam logic [31:0] EXP_TEN = 32'h4120_0000;
  localparam logic [31:0] EXP_NAN = 32'h7FC0_0000;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        frame;
    int          sent;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic        bias_wr_en = 1'b0;
  logic [1:0]  bias_wr_addr = '0;
  logic [31:0] bias_wr_data = '0;
  logic [31:0] pxl_out;
  logic        valid_out, last_px_out, frame_done;

  sbEntry_t sbQueue[$];
  int       checksTotal = 0;
  int       checksPassed = 0;
  int       cyc = 0;
  int       mPx = 0;
  int       mCh = 0;

  conv_bias_relu #(.DATA_WIDTH(32), .CHANNEL_NUM_OUT(CNO), .IMAGE_SIZE(IS)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .pxl_in       (pxl_in),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .pxl_out      (pxl_out),
    .valid_out    (valid_out),
    .last_px_out  (last_px_out),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Drive one pixel (optionally with a bias write) and queue its expected output
  task automatic applyStimulus(input logic [31:0] pxl, input logic [31:0] expected,
                               input logic wrEn, input logic [1:0] wrAddr, input logic [31:0] wrData);
    sbEntry_t e;
    @(negedge clk);
    valid_in     = 1'b1;
    pxl_in       = pxl;
    bias_wr_en   = wrEn;
    bias_wr_addr = wrAddr;
    bias_wr_data = wrData;
    e.data  = expected;
    e.last  = (mPx == IS - 1);
    e.frame = (mPx == IS - 1) && (mCh == CNO - 1);
    e.sent  = cyc;
    sbQueue.push_back(e);
    if (mPx == IS - 1) begin
      mPx = 0;
      mCh = (mCh == CNO - 1) ? 0 : mCh + 1;
    end else begin
      mPx++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in   = 1'b0;
      bias_wr_en = 1'b0;
    end
  endtask

  task automatic writeBias(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    valid_in     = 1'b0;
    bias_wr_en   = 1'b1;
    bias_wr_addr = addr;
    bias_wr_data = data;
    idle(1);
  endtask

  task automatic waitDrain;
    for (int i = 0; i < 50 && sbQueue.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(sbQueue.size()), 32'd0);
  endtask

  function automatic logic [31:0] expectedForOne(input int ch);
    case (ch)
      0:       return 32'h4000_0000;
      1:       return 32'h0000_0000;
      default: return 32'h3F80_0000;
    endcase
  endfunction

  // Pop the scoreboard whenever the design presents a pixel
  always @(posedge clk) begin
    sbEntry_t e;
    #1;
    if (valid_out) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected valid_out", 32'd1, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("pxl_out", pxl_out, e.data);
        checkOutput("last_px_out", {31'd0, last_px_out}, {31'd0, e.last});
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.frame});
        checkOutput("latency", 32'(cyc - e.sent), 32'(LAT));
      end
    end
  end

  initial begin
    int ch;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset pxl_out", pxl_out, 32'h0);
    checkOutput("reset valid_out", {31'd0, valid_out}, 32'h0);
    checkOutput("reset last_px_out", {31'd0, last_px_out}, 32'h0);
    checkOutput("reset frame_done", {31'd0, frame_done}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    writeBias(2'd0, 32'h3F80_0000);
    writeBias(2'd1, 32'hC0A0_0000);

    // First frame with gaps: ch0 bias 1.0, ch1 bias -5.0, ch2/ch3 bias 0
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 2'd0, 32'h0);
    idle(2);
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h4000_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0);
    idle(1);
    applyStimulus(32'h4120_0000, 32'h40A0_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h40A0_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'hFFC0_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h4120_0000, EXP_TEN,       1'b0, 2'd0, 32'h0);
    idle(3);
    applyStimulus(32'h40A0_0000, 32'h40A0_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h7FC0_0000, EXP_NAN,       1'b0, 2'd0, 32'h0);
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'hBF80_0000, 32'h0000_0000, 1'b0, 2'd0, 32'h0);
    idle(1);

    // Two frames back-to-back of 1.0 inputs
    for (int i = 0; i < 2 * CNO * IS; i++) begin
      ch = mCh;
      applyStimulus(32'h3F80_0000, expectedForOne(ch), 1'b0, 2'd0, 32'h0);
    end
    idle(1);
    waitDrain();

    // Bias write coinciding with a ch0 pixel: that pixel still sees the old 1.0
    applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b1, 2'd0, 32'h4000_0000);
    applyStimulus(32'h4000_0000, 32'h4080_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h3F80_0000, 32'h4040_0000, 1'b0, 2'd0, 32'h0);

    // Reset mid-plane with ch1 pixels in flight
    applyStimulus(32'h4120_0000, 32'h40A0_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h4120_0000, 32'h40A0_0000, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("midreset pxl_out", pxl_out, 32'h0);
    checkOutput("midreset valid_out", {31'd0, valid_out}, 32'h0);
    checkOutput("midreset last_px_out", {31'd0, last_px_out}, 32'h0);
    checkOutput("midreset frame_done", {31'd0, frame_done}, 32'h0);
    sbQueue.delete();
    mPx = 0;
    mCh = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(5);

    // After reset: ch0 pixel 0 again, bias back to 0
    applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b0, 2'd0, 32'h0);
    applyStimulus(32'h40A0_0000, 32'h40A0_0000, 1'b0, 2'd0, 32'h0);
    idle(1);
    waitDrain();
    idle(3);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
